// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a 4:1 mux: steps {s1,s0} through the enabled channels,
// holds each one for DWELL cycles, samples mux_out and reports a 4-bit result.
module mux_scan_ctrl #(
   parameter int DWELL = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] en_mask,
   input  logic       mux_out,
   output logic       s1,
   output logic       s0,
   output logic       busy,
   output logic       done,
   output logic [3:0] result
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      FIN    = 2'd2
   } state_t;

   localparam logic [7:0] RELOAD = 8'(DWELL - 1);

   state_t     state;
   logic [3:0] mask;
   logic [7:0] cnt;
   logic [2:0] first_ch;
   logic [2:0] next_ch;

   // Returns {found, index} of the lowest set bit of m at or above floor_idx.
   function automatic logic [2:0] lowest_from(input logic [3:0] m,
                                              input logic [2:0] floor_idx);
      logic [2:0] r;
      r = 3'b000;
      for (int i = 3; i >= 0; i--) begin
         if (m[i] && (3'(i) >= floor_idx))
            r = {1'b1, 2'(i)};
      end
      return r;
   endfunction

   assign first_ch = lowest_from(en_mask, 3'd0);
   assign next_ch  = lowest_from(mask, {1'b0, s1, s0} + 3'd1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         {s1, s0} <= 2'b00;
         busy     <= 1'b0;
         done     <= 1'b0;
         result   <= 4'b0000;
         mask     <= 4'b0000;
         cnt      <= 8'd0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  mask   <= en_mask;
                  result <= 4'b0000;
                  if (first_ch[2]) begin
                     state    <= SETTLE;
                     busy     <= 1'b1;
                     {s1, s0} <= first_ch[1:0];
                     cnt      <= RELOAD;
                  end else begin
                     state <= FIN;
                     done  <= 1'b1;
                  end
               end
            end
            SETTLE: begin
               if (cnt != 8'd0) begin
                  cnt <= cnt - 8'd1;
               end else begin
                  result[{s1, s0}] <= mux_out;
                  if (next_ch[2]) begin
                     {s1, s0} <= next_ch[1:0];
                     cnt      <= RELOAD;
                  end else begin
                     // select stays on the last channel after the scan
                     state <= FIN;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
            end
            FIN: begin
               state <= IDLE;
               done  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Randomized scoreboard bench for mux_scan_ctrl: DWELL=2 main instance plus a
// DWELL=1 instance with start held high.
module tb_mux_scan_ctrl;

   localparam int D = 2;
   localparam logic [3:0] I1 = 4'b0110;

   logic       clk = 1'b0;
   logic       rst, start, mux_out, s1, s0, busy, done;
   logic [3:0] en_mask, i_in, result;

   logic       rst1, start1, mux_out1, s1_b, s0_b, busy_b, done_b;
   logic [3:0] en_mask1, result_b;

   always #5 clk = ~clk;

   assign mux_out  = i_in[{s1, s0}];
   assign mux_out1 = I1[{s1_b, s0_b}];

   mux_scan_ctrl #(.DWELL(D)) u_dut (
      .clk(clk), .rst(rst), .start(start), .en_mask(en_mask), .mux_out(mux_out),
      .s1(s1), .s0(s0), .busy(busy), .done(done), .result(result));

   mux_scan_ctrl #(.DWELL(1)) u_dut1 (
      .clk(clk), .rst(rst1), .start(start1), .en_mask(en_mask1), .mux_out(mux_out1),
      .s1(s1_b), .s0(s0_b), .busy(busy_b), .done(done_b), .result(result_b));

   typedef struct {
      logic [3:0] res;
      int         c0;
      int         lat;
   } exp_t;

   exp_t exp_q[$];
   int   ch_list[$];
   int   cyc = 0;
   int   n_cmp = 0, n_bad = 0;
   bit   mon_on = 0, d1_on = 0, scan_on = 0;
   int   cur_c0 = 0, cur_len = 0;
   int   k1 = 0, last_done = -1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, want, cyc);
      end
   endtask

   // Reference: the scan's channel list is the ascending set bits of the mask,
   // each held D cycles from the accept edge; result is mask & inputs.
   task automatic launch(input logic [3:0] m, input logic [3:0] iv);
      i_in    = iv;
      en_mask = m;
      start   = 1'b1;
      ch_list.delete();
      for (int n = 0; n < 4; n++) if (m[n]) ch_list.push_back(n);
      cur_c0  = cyc + 1;
      cur_len = ch_list.size() * D;
      scan_on = 1;
      exp_q.push_back('{m & iv, cyc + 1, cur_len});
   endtask

   // Inputs may be scribbled on while the scan runs; the DUT must ignore them.
   task automatic issue(input logic [3:0] m, input logic [3:0] iv, input bit noise);
      int len;
      launch(m, iv);
      len = cur_len;
      for (int j = 0; j <= len; j++) begin
         @(negedge clk);
         if (noise) begin
            start   = 1'($urandom);
            en_mask = 4'($urandom);
         end else begin
            start = 1'b0;
         end
      end
      @(negedge clk);
      start   = 1'b0;
      en_mask = 4'b0000;
   endtask

   always begin : monitor
      exp_t e;
      bit   bexp;
      @(negedge clk);
      #1;
      if (mon_on) begin
         bexp = scan_on && (cyc >= cur_c0) && (cyc < cur_c0 + cur_len);
         chk("busy", 32'(busy), 32'(bexp));
         if (bexp) chk("select", 32'({s1, s0}), 32'(ch_list[(cyc - cur_c0) / D]));
         if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL done: got unexpected pulse, expected none (cycle %0d)", cyc);
            end else begin
               e = exp_q.pop_front();
               chk("result", 32'(result), 32'(e.res));
               chk("latency", 32'(cyc - e.c0), 32'(e.lat));
            end
         end
      end
   end

   always begin : monitor1
      @(negedge clk);
      #1;
      if (d1_on) begin
         if (busy_b === 1'b1) begin
            chk("d1_select", 32'({s1_b, s0_b}), 32'(k1));
            k1++;
         end
         if (done_b === 1'b1) begin
            chk("d1_channels", 32'(k1), 32'd4);
            chk("d1_result", 32'(result_b), 32'(I1));
            if (last_done >= 0) chk("d1_period", 32'(cyc - last_done), 32'd6);
            last_done = cyc;
            k1 = 0;
         end
      end
   end

   initial begin
      rst = 1'b1; start = 1'b0; en_mask = 4'b0000; i_in = 4'b0000;
      rst1 = 1'b1; start1 = 1'b0; en_mask1 = 4'b1111;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_sel", 32'({s1, s0}), 32'd0);
      chk("rst_result", 32'(result), 32'd0);
      rst = 1'b0; rst1 = 1'b0; start1 = 1'b1;
      mon_on = 1; d1_on = 1;
      @(negedge clk);

      issue(4'b1111, 4'b0101, 0);
      issue(4'b1010, 4'b0101, 0);
      issue(4'b1010, 4'b1010, 0);
      issue(4'b0000, 4'b1111, 0);

      // abort a full scan with reset at E0+3
      launch(4'b1111, 4'b1111);
      repeat (3) @(negedge clk);
      start = 1'b0;
      rst   = 1'b1;
      @(negedge clk);
      rst     = 1'b0;
      scan_on = 0;
      exp_q.delete();
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_sel", 32'({s1, s0}), 32'd0);
      chk("abort_result", 32'(result), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      repeat (10) @(negedge clk);
      issue(4'b1111, 4'b1011, 0);

      issue(4'b0111, 4'b1011, 1);
      for (int t = 0; t < 40; t++) begin
         issue(4'($urandom), 4'($urandom), 1'($urandom));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (4) @(negedge clk);
      chk("pending", 32'(exp_q.size()), 32'd0);
      mon_on = 0;
      d1_on  = 0;
      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
